branch_resolution_queue: RTL
============================

# branch_resolution_queue

Holds every in-flight branch prediction from issue until its actual outcome resolves, in program order. Compares each resolved outcome against the stored prediction, raises a one-cycle mispredict/flush pulse, and emits a training update (address + actual result) for the one-bit branch predictor directly upstream. Sits between the predictor's prediction output and the execute-stage branch unit.

## Interface
- `address_width`, 1: width of the branch address / history-table index; must match the predictor.
- `depth`, 4: queue entries; power of two, ≥2.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `pred_valid` input 1: a prediction is presented for enqueue.
- `pred_address` input `address_width`: branch address of the predicted branch.
- `pred_taken` input 1: predicted direction.
- `pred_ready` output 1: queue can accept; `1` iff count < `depth`.
- `resolve_valid` input 1: the oldest outstanding branch has resolved.
- `resolve_taken` input 1: actual direction.
- `resolve_ready` output 1: `1` iff count > 0.
- `mispredict` output 1: registered one-cycle pulse on a mismatched resolve; doubles as flush.
- `update_valid` output 1: registered one-cycle pulse per accepted resolve.
- `update_address` output `address_width`: address of the resolved branch.
- `update_result` output 1: actual direction, for predictor training.
- `resolved_count` output 16: resolves seen (stats build only).
- `mispredict_count` output 16: mispredicts seen (stats build only).

## Operation
- Push accepted on a rising edge when `pred_valid && pred_ready`; entry {address, taken} written at the tail.
- Pop accepted when `resolve_valid && resolve_ready`; head entry compared with `resolve_taken`.
- Match: head popped; `update_valid`=1, `update_address`/`update_result` from head/`resolve_taken`; `mispredict`=0.
- Mismatch: same update outputs, `mispredict`=1, and the whole queue is cleared (head=tail=0, count=0): all younger entries are wrong-path.
- Simultaneous push and pop, no mismatch: both take effect; count unchanged. Allowed at full only if `pred_ready` was already 1 (ready never depends combinationally on `resolve_valid`).
- Simultaneous push and mismatched pop: the push is discarded (wrong path); count becomes 0.
- `resolve_valid` with queue empty: ignored, no update, no count change.
- `pred_valid` while full: ignored; the source must hold it.
- Pointers are `$clog2(depth)` bits and wrap modulo `depth`; the count is `$clog2(depth)+1` bits.
- `update_*`/`mispredict` hold 0 in every cycle without an accepted resolve; `update_address`/`update_result` retain their last value but are only meaningful with `update_valid`.

## Timing
- Reset (async assert, sync release): pointers, count, `mispredict`, `update_valid`, `update_address`, `update_result` all 0, and counters 0. Hence `pred_ready`=1 and `resolve_ready`=0.
- Reset mid-operation discards all entries; no update is emitted for them.
- `pred_ready` and `resolve_ready` are combinational from registered count only.
- Resolve → `update_valid`/`mispredict`: one cycle latency, each a single-cycle pulse.
- Push → entry visible to a resolve: next cycle. There is no same-cycle bypass; `resolve_ready` is 0 when empty even if `pred_valid` is high.
- Throughput: one push and one pop per cycle.

## Configuration
- `BRANCH_RESOLUTION_STATS_EN` defined: `resolved_count` increments per accepted resolve, and `mispredict_count` per mismatch. Both saturate at 16'hFFFF and reset to 0.
- Undefined: both ports are still present, tied to 0, and no counter flops are built.

## Structure
- A shared package/header holds the stats counter width (16), the entry field layout {address, taken}, and the default depth.
- One sub-module, `brq_fifo`: a circular buffer with push/pop/clear, count, full/empty. Compare, update, and stats logic stay in the top.

## Test plan
- Reset: hold `rst`=0 with random inputs. Required: `pred_ready`=1, `resolve_ready`=0, all outputs 0, counters 0.
- Correct predictions: push addr 0 taken=1 and addr 1 taken=0, then resolve 1 and 0. Required: two `update_valid` pulses with (0,1) and (1,0), `mispredict` never 1, and (stats) resolved_count=2, mispredict_count=0.
- Full queue: 4 pushes with no resolve. Required: `pred_ready`=0 and a 5th push ignored. Then a simultaneous pop and push: the pop is accepted, the push is held, and count=3.
- Mispredict flush: push 3 entries (head taken=1), resolve taken=0 while pushing a 4th. Required: next cycle `mispredict`=1, `update_result`=0, count=0, `resolve_ready`=0, and mispredict_count=1.
- Empty resolve: `resolve_valid`=1 at count 0. Required: no `update_valid` and counters unchanged.
- Saturation (stats build): preload resolved_count to 16'hFFFE, then do 3 resolves. Required: resolved_count stays at 16'hFFFF.

Source files
------------

// File: rtl/branch_resolution_queue_pkg.sv
// ----------------------------------------------------------------------------
// branch_resolution_queue_pkg
//   Shared constants for the branch resolution queue:
//     - stats counter width
//     - queue entry layout {address, taken}, with taken in bit 0
//     - default queue depth and address width
// ----------------------------------------------------------------------------
package branch_resolution_queue_pkg;

    localparam int STATS_WIDTH           = 16;
    localparam int DEFAULT_DEPTH         = 4;
    localparam int DEFAULT_ADDRESS_WIDTH = 1;

    // Entry layout: {address[address_width-1:0], taken}
    localparam int ENTRY_TAKEN_BIT = 0;
    localparam int ENTRY_ADDR_LSB  = 1;

    function automatic int entry_width(input int address_width);
        return address_width + 1;
    endfunction

endpackage

// File: rtl/brq_fifo.sv
// ----------------------------------------------------------------------------
// brq_fifo
//   Circular buffer holding in-flight branch entries in program order.
//   Push and pop may occur in the same cycle. Clear has priority over both
//   and empties the buffer (pointers and count to zero).
//   Pushes while full and pops while empty are ignored.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   push     : write wr_data at the tail
//   pop      : advance the head
//   clear    : discard all entries
//   wr_data  : entry to write
//   rd_data  : entry at the head (valid when !empty)
//   count    : number of stored entries
//   full     : count == depth
//   empty    : count == 0
// ----------------------------------------------------------------------------
module brq_fifo
    import branch_resolution_queue_pkg::*;
#(
    parameter int width = entry_width(DEFAULT_ADDRESS_WIDTH),
    parameter int depth = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [width-1:0]       wr_data,
    output logic [width-1:0]       rd_data,
    output logic [$clog2(depth):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int ptr_w = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [ptr_w-1:0] head;
    logic [ptr_w-1:0] tail;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == depth[ptr_w:0]);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[head];

    // Depth is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop_ok)  head <= head + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[tail] <= wr_data;
    end

endmodule

// File: rtl/branch_resolution_queue.sv
// ----------------------------------------------------------------------------
// branch_resolution_queue
//   Holds in-flight branch predictions in program order until the execute
//   stage resolves them. Each resolve is compared against the oldest stored
//   prediction; a registered update pulse trains the upstream predictor and
//   a registered mispredict pulse flushes the queue (younger entries are on
//   the wrong path).
//
//   Optional feature macro: BRANCH_RESOLUTION_STATS_EN
//     defined   -> saturating resolve / mispredict counters
//     undefined -> counter ports tied to 0, no counter flops
//
// Ports
//   clk              : clock, rising edge
//   rst              : asynchronous active-low reset
//   pred_valid       : prediction presented for enqueue
//   pred_address     : branch address of the prediction
//   pred_taken       : predicted direction
//   pred_ready       : queue can accept (count < depth)
//   resolve_valid    : oldest branch has resolved
//   resolve_taken    : actual direction
//   resolve_ready    : queue holds at least one entry
//   mispredict       : one-cycle pulse on a mismatched resolve (flush)
//   update_valid     : one-cycle pulse per accepted resolve
//   update_address   : address of the resolved branch
//   update_result    : actual direction of the resolved branch
//   resolved_count   : accepted resolves (stats build)
//   mispredict_count : mispredicts (stats build)
// ----------------------------------------------------------------------------
module branch_resolution_queue
    import branch_resolution_queue_pkg::*;
#(
    parameter int address_width = DEFAULT_ADDRESS_WIDTH,
    parameter int depth         = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pred_valid,
    input  logic [address_width-1:0] pred_address,
    input  logic                     pred_taken,
    output logic                     pred_ready,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic                     resolve_ready,
    output logic                     mispredict,
    output logic                     update_valid,
    output logic [address_width-1:0] update_address,
    output logic                     update_result,
    output logic [STATS_WIDTH-1:0]   resolved_count,
    output logic [STATS_WIDTH-1:0]   mispredict_count
);

    localparam int ew = entry_width(address_width);

    logic [ew-1:0]              wr_entry;
    logic [ew-1:0]              head_entry;
    logic [$clog2(depth):0]     count;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic                       flush;
    logic                       head_taken;
    logic [address_width-1:0]   head_address;

    assign wr_entry     = {pred_address, pred_taken};
    assign head_taken   = head_entry[ENTRY_TAKEN_BIT];
    assign head_address = head_entry[ew-1:ENTRY_ADDR_LSB];

    // Ready flags come only from the registered count, never from the
    // opposite side's valid, so a push at full waits even if a pop happens.
    assign pred_ready    = !full;
    assign resolve_ready = !empty;

    assign pop   = resolve_valid && resolve_ready;
    assign flush = pop && (head_taken != resolve_taken);
    assign push  = pred_valid && pred_ready;

    // A flush clears the buffer and so also drops a same-cycle push.
    brq_fifo #(
        .width (ew),
        .depth (depth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .clear   (flush),
        .wr_data (wr_entry),
        .rd_data (head_entry),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            update_valid   <= 1'b0;
            mispredict     <= 1'b0;
            update_address <= '0;
            update_result  <= 1'b0;
        end else begin
            update_valid <= pop;
            mispredict   <= flush;
            if (pop) begin
                update_address <= head_address;
                update_result  <= resolve_taken;
            end
        end
    end

`ifdef BRANCH_RESOLUTION_STATS_EN
    logic [STATS_WIDTH-1:0] resolved_q;
    logic [STATS_WIDTH-1:0] mispredict_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resolved_q   <= '0;
            mispredict_q <= '0;
        end else begin
            if (pop && (resolved_q != '1))     resolved_q   <= resolved_q + 1'b1;
            if (flush && (mispredict_q != '1)) mispredict_q <= mispredict_q + 1'b1;
        end
    end

    assign resolved_count   = resolved_q;
    assign mispredict_count = mispredict_q;
`else
    assign resolved_count   = '0;
    assign mispredict_count = '0;
`endif

endmodule
